keypad_scanner: RTL and testbench

- Input-side counterpart of the multiplexed seven-segment driver.
- Scans a 4x4 hex keypad matrix by driving one column low at a time and sampling the active-low row lines.
- Debounces presses, encodes each accepted key to a 4-bit hex code and hands it off with a valid/ready handshake.
- Output is directly usable as one digit of the display's encoded input.

---
 rtl/keypad_pkg.sv | 46 ++++
 rtl/sync_2ff.sv | 26 ++
 rtl/keypad_scanner.sv | 168 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 hex keypad scanner.
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;

  typedef enum logic [1:0] {StScan, StDebounce, StRelease} state_e;

  // Rows top to bottom, columns left to right.
  function automatic logic [3:0] keymap(input logic [1:0] row_idx, input logic [1:0] col_idx);
    logic [3:0] code;
    case ({row_idx, col_idx})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'h0;
      4'hD: code = 4'hF;
      4'hE: code = 4'hE;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  function automatic logic single_low(input logic [NUM_ROWS-1:0] rows);
    return $countones(~rows) == 1;
  endfunction

  function automatic logic [1:0] low_index(input logic [NUM_ROWS-1:0] rows);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
  parameter int unsigned       Width    = 1,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta_q, sync_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with debounce, hex encoding and valid/ready hand-off.
// Define KEYPAD_REPEAT_EN to build the auto-repeat logic for held keys.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_INTERVAL  = 10000,
  parameter int unsigned DEBOUNCE_COUNT = 4,
  parameter int unsigned REPEAT_DELAY   = 50,
  parameter int unsigned REPEAT_RATE    = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic [3:0]          key_code,
  output logic                key_valid,
  input  logic                key_ready,
  output logic                overrun
);

  localparam int unsigned SlotW = (SCAN_INTERVAL > 1) ? $clog2(SCAN_INTERVAL) : 1;
  localparam int unsigned DbW   = $clog2(DEBOUNCE_COUNT + 1);
  localparam logic [SlotW-1:0] SlotLast = SlotW'(SCAN_INTERVAL - 1);
  localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_COUNT - 1);

  logic [NUM_ROWS-1:0] row_s;
  logic [SlotW-1:0]    slot_q;
  logic [1:0]          col_idx_q, cand_row_q;
  logic [NUM_COLS-1:0] col_q;
  state_e              state_q;
  logic [DbW-1:0]      match_q, rel_q;
  logic [3:0]          key_code_q;
  logic                key_valid_q, overrun_q;

  logic tick, one_low, same_row, all_high, advance, accept, consume, repeat_fire;

  sync_2ff #(
    .Width    (NUM_ROWS),
    .ResetVal ({NUM_ROWS{1'b1}})
  ) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row),
    .q     (row_s)
  );

  assign tick     = (slot_q == SlotLast);
  assign one_low  = single_low(row_s);
  assign same_row = one_low && (low_index(row_s) == cand_row_q);
  assign all_high = &row_s;
  assign consume  = key_valid_q && key_ready;

  always_comb begin
    advance = 1'b0;
    if (tick) begin
      unique case (state_q)
        StScan:     advance = !one_low;
        StDebounce: advance = !same_row;
        StRelease:  advance = all_high && (rel_q == DbLast);
        default:    advance = 1'b0;
      endcase
    end
  end

  assign accept = (state_q == StDebounce && tick && same_row && match_q == DbLast) || repeat_fire;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned HoldW = $clog2(REPEAT_DELAY + 1);
  localparam int unsigned RateW = (REPEAT_RATE > 1) ? $clog2(REPEAT_RATE) : 1;
  localparam logic [HoldW-1:0] HoldFull = HoldW'(REPEAT_DELAY);
  localparam logic [RateW-1:0] RateLast = RateW'(REPEAT_RATE - 1);

  logic [HoldW-1:0] hold_q;
  logic [RateW-1:0] rate_q;
  logic             held;

  assign held = !row_s[cand_row_q];

  // hold_q saturates at the delay; rate_q then paces the follow-on repeats.
  always_comb begin
    repeat_fire = 1'b0;
    if (state_q == StRelease && tick && held) begin
      if (hold_q == HoldFull - 1'b1)                       repeat_fire = 1'b1;
      else if (hold_q == HoldFull && rate_q == RateLast)   repeat_fire = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_q <= '0;
      rate_q <= '0;
    end else if (state_q != StRelease || (tick && !held)) begin
      hold_q <= '0;
      rate_q <= '0;
    end else if (tick) begin
      if (hold_q != HoldFull) hold_q <= hold_q + 1'b1;
      else                    rate_q <= (rate_q == RateLast) ? '0 : rate_q + 1'b1;
    end
  end
`else
  assign repeat_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_q      <= '0;
      col_idx_q   <= '0;
      col_q       <= 4'b1110;
      state_q     <= StScan;
      cand_row_q  <= '0;
      match_q     <= '0;
      rel_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      slot_q <= tick ? '0 : slot_q + 1'b1;

      if (advance) begin
        col_idx_q <= col_idx_q + 1'b1;
        col_q     <= {col_q[NUM_COLS-2:0], col_q[NUM_COLS-1]};
      end

      if (tick) begin
        unique case (state_q)
          StScan: begin
            if (one_low) begin
              cand_row_q <= low_index(row_s);
              match_q    <= DbW'(1);
              state_q    <= StDebounce;
            end
          end
          StDebounce: begin
            if (!same_row) begin
              state_q <= StScan;
            end else if (match_q == DbLast) begin
              state_q <= StRelease;
              rel_q   <= '0;
            end else begin
              match_q <= match_q + 1'b1;
            end
          end
          StRelease: begin
            if (!all_high)             rel_q   <= '0;
            else if (rel_q == DbLast)  state_q <= StScan;
            else                       rel_q   <= rel_q + 1'b1;
          end
          default: state_q <= StScan;
        endcase
      end

      // Newest key wins; an unconsumed older key flags overrun.
      if (accept) begin
        key_code_q  <= keymap(cand_row_q, col_idx_q);
        key_valid_q <= 1'b1;
        if (key_valid_q && !key_ready) overrun_q <= 1'b1;
      end else if (consume) begin
        key_valid_q <= 1'b0;
      end
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a combinational keypad matrix model.
module tb_keypad_scanner;

  logic       clk, reset;
  logic [3:0] row, col, key_code;
  logic       key_valid, key_ready, overrun;

  logic [15:0] keys;      // keys[r*4+c] pressed
  logic        row_zero;

  int n_checks = 0;
  int n_fail   = 0;

  keypad_scanner #(
    .SCAN_INTERVAL  (4),
    .DEBOUNCE_COUNT (3),
    .REPEAT_DELAY   (5),
    .REPEAT_RATE    (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && col[c] === 1'b0) row[r] = 1'b0;
      end
    end
    if (row_zero) row = 4'h0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; key_ready = 1'b0; keys = '0; row_zero = 1'b1;
    step(3);
    check("rst_col", col, 4'b1110);
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b1; row_zero = 1'b0;

    // Column walk, one column per 4 cycles.
    step(4); check("walk_c1", col, 4'b1101);
    step(4); check("walk_c2", col, 4'b1011);
    step(4); check("walk_c3", col, 4'b0111);
    step(4); check("walk_c0", col, 4'b1110);

    // Clean press of "8" (row 2, col 1).
    keys = 16'h0001 << 9;
    step(15);
    check("press_pre_valid", key_valid, 0);
    step(1);
    check("press_valid", key_valid, 1);
    check("press_code", key_code, 4'h8);
    check("press_col_frozen", col, 4'b1101);
    key_ready = 1'b1;
    step(1);
    key_ready = 1'b0;
    check("press_consumed", key_valid, 0);
    step(8);
    check("press_held_no_key", key_valid, 0);
    keys = '0;
    step(10);
    check("release_col_held", col, 4'b1101);
    step(1);
    check("release_col_adv", col, 4'b1011);
    check("release_no_key", key_valid, 0);

    // Bounce: "A" (row 0, col 3) seen for two ticks only.
    keys = 16'h0001 << 3;
    step(12);
    check("bounce_col_frozen", col, 4'b0111);
    keys = '0;
    step(4);
    check("bounce_col_resume", col, 4'b1110);
    check("bounce_no_key", key_valid, 0);

    // Ghosting: rows 0 and 2 low on col 0.
    keys = (16'h0001 << 0) | (16'h0001 << 8);
    step(4);
    check("ghost_row_pattern_col", col, 4'b1101);
    check("ghost_no_key", key_valid, 0);
    keys = '0;

    // Overrun: "1" then "D" without consuming.
    keys = 16'h0001 << 0;
    step(23);
    check("ovr_first_pre", key_valid, 0);
    step(1);
    check("ovr_first_valid", key_valid, 1);
    check("ovr_first_code", key_code, 4'h1);
    keys = '0;
    step(12);
    check("ovr_rescan_col", col, 4'b1101);
    keys = 16'h0001 << 15;
    step(19);
    check("ovr_pre_flag", overrun, 0);
    check("ovr_pre_code", key_code, 4'h1);
    step(1);
    check("ovr_code", key_code, 4'hD);
    check("ovr_valid", key_valid, 1);
    check("ovr_flag", overrun, 1);
    key_ready = 1'b1;
    step(1);
    key_ready = 1'b0;
    check("ovr_consumed", key_valid, 0);
    check("ovr_sticky", overrun, 1);
    keys = '0;
    step(12);

    // Reset while debouncing "5" (row 1, col 1).
    keys = 16'h0001 << 5;
    step(8);
    check("mid_col_frozen", col, 4'b1101);
    reset = 1'b0;
    step(1);
    check("mid_rst_col", col, 4'b1110);
    check("mid_rst_valid", key_valid, 0);
    check("mid_rst_code", key_code, 0);
    check("mid_rst_overrun", overrun, 0);
    reset = 1'b1;

`ifdef KEYPAD_REPEAT_EN
    // Hold "5": accept at tick 4 after release, repeats 5,7,9,11 ticks into RELEASE.
    begin
      int n_valid;
      n_valid = 0;
      key_ready = 1'b1;
      for (int i = 0; i < 64; i++) begin
        step(1);
        if (key_valid) n_valid++;
      end
      key_ready = 1'b0;
      check("repeat_count", n_valid, 5);
      check("repeat_code", key_code, 4'h5);
    end
`endif
    keys = '0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
